// File: rtl/instr_sequencer_if.sv
// Program-load and CU-facing instruction bus of the sequencer.
// No latency of its own; a plain bundle of wires.
// No backpressure: load and start are single-edge strobes, outputs are level.
interface instr_sequencer_if #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
);
    logic                   load_en;
    logic [PC_BITS-1:0]     load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   start;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_BITS-1:0]     pc;
    logic                   busy;
    logic                   done;
    logic [7:0]             retired;

    // Side that loads the program, starts it and watches progress.
    modport master (
        output load_en, load_addr, load_data, start,
        input  instr, pc, busy, done, retired
    );

    // The sequencer itself.
    modport slave (
        input  load_en, load_addr, load_data, start,
        output instr, pc, busy, done, retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// Steps a PC through a writable program memory, holding each word on instr for its class's cycle count.
// Start edge loads instr (valid next cycle); first word held N+1 cycles, later words N; done one cycle after last retire.
// No backpressure: start and load_en are simply ignored while busy.
module instr_sequencer #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS     = 5
) (
    input  logic               clk,
    input  logic               rst,
    instr_sequencer_if.slave   bus
);
    localparam int DEPTH = 1 << PC_BITS;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_BITS-1:0]     pc_q, pc_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [7:0]             retired_q, retired_d;
    logic [2:0]             cnt_q, cnt_d;

    logic [PC_BITS-1:0]     pc_inc;
    logic [INSTR_WIDTH-1:0] first_word;
    logic [INSTR_WIDTH-1:0] next_word;
    logic [2:0]             first_n;
    logic [2:0]             next_n;

    // Cycles the CU's FSM spends on each class; 0 marks HALT.
    function automatic logic [2:0] hold_cnt(input logic [1:0] cls);
        case (cls)
            2'b01:   hold_cnt = 3'd3;
            2'b10:   hold_cnt = 3'd4;
            2'b11:   hold_cnt = 3'd3;
            default: hold_cnt = 3'd0;
        endcase
    endfunction

    assign pc_inc     = pc_q + PC_BITS'(1);
    assign first_word = mem_q[0];
    assign next_word  = mem_q[pc_inc];
    assign first_n    = hold_cnt(first_word[INSTR_WIDTH-1 -: 2]);
    assign next_n     = hold_cnt(next_word[INSTR_WIDTH-1 -: 2]);

    // Program memory: written only while idle, deliberately not reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (bus.load_en && !busy_q) begin
            mem_q[bus.load_addr] <= bus.load_data;
        end
    end

    // Next-state and output computation for the IDLE/RUN sequencer.
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        pc_d      = pc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pc_d      = '0;
                    retired_d = '0;
                    if (first_n == 3'd0) begin
                        done_d = 1'b1;
                    end else begin
                        // Extra cycle covers the CU's RESET->DECODE exit.
                        instr_d = first_word;
                        cnt_d   = first_n + 3'd1;
                        busy_d  = 1'b1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q > 3'd1) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    retired_d = (retired_q == 8'hFF) ? retired_q : retired_q + 8'd1;
                    // The PC never wraps: the last address always halts.
                    if ((&pc_q) || (next_n == 3'd0)) begin
                        instr_d = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        cnt_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        instr_d = next_word;
                        pc_d    = pc_inc;
                        cnt_d   = next_n;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drives class 00 onto instr so the CU stays in RESET.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            pc_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            retired_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            retired_q <= retired_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.instr   = instr_q;
    assign bus.pc      = pc_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.retired = retired_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table programs, hand-written corner sequences,
// and random programs compared cycle by cycle against an execution-trace model.
// Inputs change just after the falling edge; outputs are sampled on the falling edge.
module tb_instr_sequencer;
    localparam int IW    = 20;
    localparam int PB    = 5;
    localparam int DEPTH = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_sequencer_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) bus();

    instr_sequencer #(.INSTR_WIDTH(IW), .PC_BITS(PB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [IW-1:0] instr;
        logic [PB-1:0] pc;
        logic          busy;
        logic          done;
        logic [7:0]    retired;
    } obs_t;

    typedef struct {
        string         name;
        logic [IW-1:0] w0, w1, w2, w3;
        int            exp_ret;
        int            exp_busy;
    } vec_t;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [IW-1:0] ref_mem [DEPTH];
    obs_t          exp_q[$];

    function automatic obs_t observe();
        obs_t o;
        o.instr   = bus.instr;
        o.pc      = bus.pc;
        o.busy    = bus.busy;
        o.done    = bus.done;
        o.retired = bus.retired;
        return o;
    endfunction

    function automatic int hold_of(input logic [IW-1:0] w);
        case (w[IW-1:IW-2])
            2'b01:   return 3;
            2'b10:   return 4;
            2'b11:   return 3;
            default: return 0;
        endcase
    endfunction

    function automatic obs_t mk(input logic [IW-1:0] i, input int p, input logic b,
                                input logic d, input int r);
        obs_t o;
        o.instr   = i;
        o.pc      = PB'(p);
        o.busy    = b;
        o.done    = d;
        o.retired = (r > 255) ? 8'hFF : 8'(r);
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs after a start edge: walk the program, each word
    // visible for its hold count (+1 for the first), then one done cycle.
    task automatic build_trace();
        int n;
        int h;
        exp_q.delete();
        n = 0;
        for (int a = 0; a < DEPTH; a++) begin
            h = hold_of(ref_mem[a]);
            if (h == 0) break;
            if (a == 0) h = h + 1;
            for (int k = 0; k < h; k++) exp_q.push_back(mk(ref_mem[a], a, 1'b1, 1'b0, n));
            n++;
        end
        exp_q.push_back(mk('0, (n == 0) ? 0 : n - 1, 1'b0, 1'b1, n));
    endtask

    task automatic push_mem();
        for (int a = 0; a < DEPTH; a++) begin
            bus.load_en   = 1'b1;
            bus.load_addr = PB'(a);
            bus.load_data = ref_mem[a];
            @(negedge clk);
        end
        bus.load_en = 1'b0;
    endtask

    task automatic clear_ref();
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = '0;
    endtask

    // Start the program, compare every cycle against the model. At cycle inject_at
    // a start and a write of mem[0] are attempted while busy.
    task automatic run_check(input string tag, input int inject_at,
                             output int busy_cycles, output int ret);
        obs_t act;
        obs_t fin;
        build_trace();
        busy_cycles = 0;
        bus.start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            bus.start   = 1'b0;
            bus.load_en = 1'b0;
            act = observe();
            check({tag, " trace"}, 64'(act), 64'(exp_q[i]));
            if (act.busy) busy_cycles++;
            if (i == inject_at) begin
                bus.start     = 1'b1;
                bus.load_en   = 1'b1;
                bus.load_addr = '0;
                bus.load_data = '1;
            end
        end
        ret = int'(act.retired);
        fin = exp_q[exp_q.size() - 1];
        fin.done = 1'b0;
        @(negedge clk);
        check({tag, " idle after done"}, 64'(observe()), 64'(fin));
    endtask

    vec_t vt[6];
    int   bc, rt, bc2, rt2;
    obs_t o;
    bit   seen;

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst           = 1'b0;
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;

        vt[0] = '{"single std_op", 20'h41234, 20'h0, 20'h0, 20'h0, 1, 4};
        vt[1] = '{"mixed", 20'h40001, 20'h80015, 20'hC0020, 20'h0, 3, 11};
        vt[2] = '{"halt at 0", 20'h0, 20'h41111, 20'h0, 20'h0, 0, 0};
        vt[3] = '{"single loadR", 20'h80015, 20'h0, 20'h0, 20'h0, 1, 5};
        vt[4] = '{"storeR first", 20'hC0001, 20'h40002, 20'h0, 20'h0, 2, 7};
        vt[5] = '{"loadR storeR loadR", 20'h80001, 20'hC0002, 20'h80003, 20'h0, 3, 12};

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset state", 64'(observe()), 64'(mk('0, 0, 1'b0, 1'b0, 0)));
        rst = 1'b1;
        @(negedge clk);

        // Table-driven programs.
        foreach (vt[t]) begin
            clear_ref();
            ref_mem[0] = vt[t].w0;
            ref_mem[1] = vt[t].w1;
            ref_mem[2] = vt[t].w2;
            ref_mem[3] = vt[t].w3;
            push_mem();
            run_check(vt[t].name, -1, bc, rt);
            check({vt[t].name, " busy cycles"}, 64'(bc), 64'(vt[t].exp_busy));
            check({vt[t].name, " retired"}, 64'(rt), 64'(vt[t].exp_ret));
        end

        // Blocked start and load while busy on the mixed program; rerun proves mem[0] intact.
        clear_ref();
        ref_mem[0] = 20'h40001; ref_mem[1] = 20'h80015; ref_mem[2] = 20'hC0020;
        push_mem();
        run_check("blocked inputs", 5, bc, rt);
        check("blocked busy cycles", 64'(bc), 64'd11);
        check("blocked retired", 64'(rt), 64'd3);
        run_check("blocked rerun", -1, bc, rt);
        check("blocked rerun retired", 64'(rt), 64'd3);

        // Asynchronous reset mid-run, then an identical re-run.
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async reset mid-run", 64'(observe()), 64'(mk('0, 0, 1'b0, 1'b0, 0)));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_check("post-reset rerun", -1, bc2, rt2);
        check("post-reset busy cycles", 64'(bc2), 64'd11);
        check("post-reset retired", 64'(rt2), 64'd3);

        // Start and load on the halt edge are ignored; start one edge later is accepted.
        clear_ref();
        ref_mem[0] = 20'h41234;
        push_mem();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("last hold cycle", 64'(observe()), 64'(mk(20'h41234, 0, 1'b1, 1'b0, 0)));
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = '0;
        bus.load_data = 20'h45555;
        @(negedge clk);
        bus.load_en = 1'b0;
        check("start on halt edge ignored", 64'(observe()), 64'(mk('0, 0, 1'b0, 1'b1, 1)));
        @(negedge clk);
        bus.start = 1'b0;
        check("start after halt accepted", 64'(observe()), 64'(mk(20'h41234, 0, 1'b1, 1'b0, 0)));
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("second run done seen", 64'(seen), 64'd1);
        check("second run retired", 64'(bus.retired), 64'd1);

        // Full memory of std_ops: no wrap, 32 retired.
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = {2'b01, 18'($urandom)};
        push_mem();
        run_check("full memory", -1, bc, rt);
        check("full busy cycles", 64'(bc), 64'd97);
        check("full retired", 64'(rt), 64'd32);
        check("full final pc", 64'(bus.pc), 64'd31);

        // Random programs against the trace model.
        for (int r = 0; r < 20; r++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 11) == 0)
                    ref_mem[a] = {2'b00, 18'($urandom)};
                else
                    ref_mem[a] = {2'($urandom_range(1, 3)), 18'($urandom)};
            end
            push_mem();
            run_check("random", -1, bc, rt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
